apb_to_obi_bridge: RTL and testbench

Parametrised APB4-subordinate to OBI-manager bridge, the successor to the fixed 32-bit, struct-port APB-to-OBI wrapper. It converts one APB transfer at a time into one OBI transaction, with configurable address/data widths and an optional APB3 mode without strobes. It adds OBI error forwarding to PSLVERR and a response timeout that aborts hung subordinates and drains late responses. It sits between the APB peripheral bus and OBI-attached IP in the X-HEEP-style subsystem, using flat OBI signals so no format-conversion glue is needed.

---
 rtl/apb_to_obi_bridge.sv | 170 +++++++++++++++++
 tb/tb_apb_to_obi_bridge.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_to_obi_bridge.sv
// APB4/APB3 subordinate to OBI manager bridge: one APB transfer becomes one OBI
// transaction, with error forwarding and a response timeout that drains late responses.
module apb_to_obi_bridge #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter bit          Apb4          = 1'b1,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   psel_i,
  input  logic                   penable_i,
  input  logic                   pwrite_i,
  input  logic [AddrWidth-1:0]   paddr_i,
  input  logic [DataWidth-1:0]   pwdata_i,
  input  logic [DataWidth/8-1:0] pstrb_i,
  output logic [DataWidth-1:0]   prdata_o,
  output logic                   pready_o,
  output logic                   pslverr_o,
  output logic                   obi_req_o,
  output logic                   obi_we_o,
  output logic [DataWidth/8-1:0] obi_be_o,
  output logic [AddrWidth-1:0]   obi_addr_o,
  output logic [DataWidth-1:0]   obi_wdata_o,
  input  logic                   obi_gnt_i,
  input  logic                   obi_rvalid_i,
  input  logic                   obi_err_i,
  input  logic [DataWidth-1:0]   obi_rdata_i
);

  localparam int unsigned BeW       = DataWidth / 8;
  localparam bit          TimeoutEn = (TimeoutCycles > 0);
  localparam int unsigned CntW      = TimeoutEn ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW:0] TimeoutVal = TimeoutCycles[CntW:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RSP,
    S_DONE
  } state_e;

  state_e               r_state;
  state_e               w_state_nxt;
  logic                 r_drain;
  logic                 w_drain_nxt;
  logic [CntW-1:0]      r_cnt;
  logic [CntW-1:0]      w_cnt_nxt;
  logic [CntW:0]        w_cnt_inc;
  logic                 w_expire;
  logic                 w_accept;
  logic                 w_apb_done;
  logic                 w_capture;
  logic                 w_rsp_load;
  logic                 w_abort;
  logic                 w_pready;

  logic [AddrWidth-1:0] r_addr;
  logic [DataWidth-1:0] r_wdata;
  logic                 r_we;
  logic [BeW-1:0]       r_be;
  logic [DataWidth-1:0] r_rdata;
  logic                 r_err;

  // The extra counter bit keeps the compare correct when a grant at expiry lets it run past the limit.
  assign w_cnt_inc  = {1'b0, r_cnt} + {{CntW{1'b0}}, 1'b1};
  assign w_expire   = TimeoutEn && (w_cnt_inc >= TimeoutVal);
  assign w_accept   = (r_state == S_IDLE) && psel_i && !r_drain;
  assign w_apb_done = psel_i && penable_i;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_drain_nxt = r_drain;
    w_capture   = 1'b0;
    w_rsp_load  = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        w_cnt_nxt = w_cnt_inc[CntW-1:0];
        if (obi_gnt_i) begin
          w_state_nxt = S_RSP;
        end else if (w_expire) begin
          w_abort     = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_RSP: begin
        w_cnt_nxt = w_cnt_inc[CntW-1:0];
        if (obi_rvalid_i) begin
          w_rsp_load  = 1'b1;
          w_state_nxt = S_DONE;
        end else if (w_expire) begin
          w_abort     = 1'b1;
          w_drain_nxt = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (w_apb_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A response still owed by an aborted subordinate is swallowed here, or given up on at expiry.
    if (r_drain && (r_state != S_RSP)) begin
      w_cnt_nxt = w_cnt_inc[CntW-1:0];
      if (obi_rvalid_i || w_expire) begin
        w_drain_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_drain <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_drain <= w_drain_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_capture) begin
        r_addr  <= paddr_i;
        r_wdata <= pwdata_i;
        r_we    <= pwrite_i;
        r_be    <= (pwrite_i && Apb4) ? pstrb_i : '1;
      end
      if (w_rsp_load) begin
        r_rdata <= (r_we || obi_err_i) ? '0 : obi_rdata_i;
        r_err   <= obi_err_i;
      end else if (w_abort) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end
    end
  end

  assign w_pready    = (r_state == S_DONE) && w_apb_done;
  assign pready_o    = w_pready;
  assign prdata_o    = w_pready ? r_rdata : '0;
  assign pslverr_o   = w_pready ? r_err : 1'b0;
  assign obi_req_o   = (r_state == S_REQ);
  assign obi_we_o    = r_we;
  assign obi_be_o    = r_be;
  assign obi_addr_o  = r_addr;
  assign obi_wdata_o = r_wdata;

endmodule

// File: tb/tb_apb_to_obi_bridge.sv
// Bench for apb_to_obi_bridge: directed table, drain/reset sequences and randomized
// transfers checked against a transfer-level timing model.
module tb_apb_to_obi_bridge;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic        gnt, rvalid, oerr;
  logic [31:0] rdata;

  logic [31:0] prdata0, prdata1, addr0, addr1, wdata0, wdata1;
  logic        pready0, pready1, pslverr0, pslverr1, req0, req1, we0, we1;
  logic [3:0]  be0, be1;

  always #5 clk = ~clk;

  apb_to_obi_bridge #(.AddrWidth(32), .DataWidth(32), .Apb4(1'b1), .TimeoutCycles(TO)) u_apb4 (
    .clk_i(clk), .rst_i(rst), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb), .prdata_o(prdata0),
    .pready_o(pready0), .pslverr_o(pslverr0), .obi_req_o(req0), .obi_we_o(we0),
    .obi_be_o(be0), .obi_addr_o(addr0), .obi_wdata_o(wdata0), .obi_gnt_i(gnt),
    .obi_rvalid_i(rvalid), .obi_err_i(oerr), .obi_rdata_i(rdata));

  apb_to_obi_bridge #(.AddrWidth(32), .DataWidth(32), .Apb4(1'b0), .TimeoutCycles(TO)) u_apb3 (
    .clk_i(clk), .rst_i(rst), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb), .prdata_o(prdata1),
    .pready_o(pready1), .pslverr_o(pslverr1), .obi_req_o(req1), .obi_we_o(we1),
    .obi_be_o(be1), .obi_addr_o(addr1), .obi_wdata_o(wdata1), .obi_gnt_i(gnt),
    .obi_rvalid_i(rvalid), .obi_err_i(oerr), .obi_rdata_i(rdata));

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          g;        // grant delay in request cycles (>= TO: never)
    int          r;        // rvalid delay after the grant cycle
    logic [31:0] rdata;
    logic        err;
    int          lrv;      // cycle of a stray late rvalid, -1 for none
    int          e_req_cycle;
    int          e_req_cnt;
    int          e_pready;
    logic [31:0] e_prdata;
    logic        e_err;
    logic [3:0]  e_be;
  } vec_t;

  typedef struct {
    int          req_cycle;
    int          req_cnt;
    int          pready_c;
    logic [31:0] prd0, prd1;
    logic        perr0, perr1, rdy1;
    logic [3:0]  be0s, be1s;
    logic        wes;
    logic [31:0] addrs, wdatas;
    logic        stable;
  } res_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Transfer-level expectations from the bridge's timing rules (TO-cycle budget over REQ+RSP).
  function automatic vec_t model(input vec_t v);
    vec_t m;
    int   rc, abort_i;
    m  = v;
    rc = (v.lrv >= 0) ? v.lrv + 2 : 1;
    m.e_req_cycle = rc;
    m.e_be = v.wr ? v.strb : 4'hF;
    if (v.g >= TO) begin
      m.e_req_cnt = TO;
      m.e_pready  = rc + TO;
      m.e_err     = 1'b1;
      m.e_prdata  = '0;
    end else if (v.r >= 1 && v.g + v.r >= TO - 1) begin
      abort_i     = (v.g + 1 > TO - 1) ? v.g + 1 : TO - 1;
      m.e_req_cnt = v.g + 1;
      m.e_pready  = rc + abort_i + 1;
      m.e_err     = 1'b1;
      m.e_prdata  = '0;
    end else begin
      m.e_req_cnt = v.g + 1;
      m.e_pready  = rc + 2 + v.g + v.r;
      m.e_err     = v.err;
      m.e_prdata  = (v.wr || v.err) ? 32'h0 : v.rdata;
    end
    return m;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; gnt = 1'b0; rvalid = 1'b0; oerr = 1'b0;
    end
  endtask

  task automatic run_xfer(input vec_t v, output res_t res);
    int req_k  = 0;
    int gnt_at = -1;
    res.req_cycle = -1; res.req_cnt = 0; res.pready_c = -1; res.stable = 1'b1;
    res.prd0 = 'x; res.prd1 = 'x; res.perr0 = 1'bx; res.perr1 = 1'bx; res.rdy1 = 1'b0;
    res.be0s = 'x; res.be1s = 'x; res.wes = 1'bx; res.addrs = 'x; res.wdatas = 'x;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      gnt = 1'b0; rvalid = 1'b0; oerr = 1'b0; rdata = $urandom;
      if (c == 0) begin
        psel = 1'b1; penable = 1'b0; pwrite = v.wr; paddr = v.addr;
        pwdata = v.wdata; pstrb = v.strb;
      end else begin
        penable = 1'b1;
      end
      if (req0) begin
        if (req_k == v.g) begin gnt = 1'b1; gnt_at = c; end
        req_k++;
      end
      if (gnt_at >= 0 && c == gnt_at + 1 + v.r) begin
        rvalid = 1'b1; rdata = v.rdata; oerr = v.err;
      end
      if (c == v.lrv) begin
        rvalid = 1'b1; rdata = $urandom; oerr = 1'b1;
      end
      #1;
      if (req0) begin
        if (res.req_cycle < 0) begin
          res.req_cycle = c; res.be0s = be0; res.be1s = be1; res.wes = we0;
          res.addrs = addr0; res.wdatas = wdata0;
        end else if (be0 !== res.be0s || we0 !== res.wes || addr0 !== res.addrs || wdata0 !== res.wdatas) begin
          res.stable = 1'b0;
        end
        res.req_cnt++;
      end
      if (pready0) begin
        res.pready_c = c; res.prd0 = prdata0; res.perr0 = pslverr0;
        res.rdy1 = pready1; res.prd1 = prdata1; res.perr1 = pslverr1;
        break;
      end
    end
  endtask

  task automatic compare(input string tag, input vec_t e, input res_t r);
    chk({tag, ".req_cycle"}, r.req_cycle, e.e_req_cycle);
    chk({tag, ".req_cnt"},   r.req_cnt,   e.e_req_cnt);
    chk({tag, ".pready_cyc"}, r.pready_c, e.e_pready);
    chk({tag, ".prdata"},    r.prd0,      e.e_prdata);
    chk({tag, ".pslverr"},   32'(r.perr0), 32'(e.e_err));
    chk({tag, ".apb3_ready"}, 32'(r.rdy1), 32'h1);
    chk({tag, ".apb3_prdata"}, r.prd1,    e.e_prdata);
    chk({tag, ".apb3_slverr"}, 32'(r.perr1), 32'(e.e_err));
    chk({tag, ".be"},        32'(r.be0s), 32'(e.e_be));
    chk({tag, ".apb3_be"},   32'(r.be1s), 32'hF);
    chk({tag, ".we"},        32'(r.wes),  32'(e.wr));
    chk({tag, ".addr"},      r.addrs,     e.addr);
    chk({tag, ".wdata"},     r.wdatas,    e.wdata);
    chk({tag, ".stable"},    32'(r.stable), 32'h1);
  endtask

  vec_t tbl[8];
  vec_t v, m;
  res_t res;

  initial begin
    //             wr    addr        wdata         strb  g   r  rdata         err  lrv rc cnt rdy prdata        err  be
    tbl[0] = '{1'b1, 32'h40, 32'hDEADBEEF, 4'h3, 0,  0, 32'hFFFFFFFF, 1'b0, -1, 1, 1,  3, 32'h0,        1'b0, 4'h3};
    tbl[1] = '{1'b0, 32'h80, 32'h0,        4'h0, 4,  0, 32'h12345678, 1'b0, -1, 1, 5,  7, 32'h12345678, 1'b0, 4'hF};
    tbl[2] = '{1'b0, 32'h84, 32'h0,        4'h0, 1,  1, 32'hCAFEF00D, 1'b1, -1, 1, 2,  5, 32'h0,        1'b1, 4'hF};
    tbl[3] = '{1'b1, 32'h88, 32'h01020304, 4'h1, 0,  2, 32'h5A5A5A5A, 1'b0, -1, 1, 1,  5, 32'h0,        1'b0, 4'h1};
    tbl[4] = '{1'b0, 32'h8C, 32'h0,        4'h0, 0,  6, 32'hA5A5A5A5, 1'b0, -1, 1, 1,  9, 32'hA5A5A5A5, 1'b0, 4'hF};
    tbl[5] = '{1'b0, 32'h90, 32'h0,        4'h0, 7,  0, 32'h0BADCAFE, 1'b0, -1, 1, 8, 10, 32'h0BADCAFE, 1'b0, 4'hF};
    tbl[6] = '{1'b1, 32'h94, 32'h00000077, 4'hC, 99, 0, 32'h11111111, 1'b0, -1, 1, 8,  9, 32'h0,        1'b1, 4'hC};
    tbl[7] = '{1'b0, 32'h98, 32'h0,        4'h0, 0,  0, 32'h13579BDF, 1'b0, -1, 1, 1,  3, 32'h13579BDF, 1'b0, 4'hF};

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    pstrb = '0; gnt = 1'b0; rvalid = 1'b0; oerr = 1'b0; rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.ctl", {28'h0, req0, pready0, pslverr0, we0}, 32'h0);
    chk("reset.be", {28'h0, be0}, 32'h0);
    chk("reset.addr", addr0, 32'h0);
    chk("reset.wdata", wdata0, 32'h0);
    chk("reset.prdata", prdata0, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_xfer(tbl[i], res);
      compare($sformatf("tbl%0d", i), tbl[i], res);
    end

    // Late response arrives while draining: the next transfer waits for it.
    idle(1);
    v = '{1'b0, 32'h200, 32'h0, 4'h0, 0, 20, 32'h11111111, 1'b0, -1, 0, 0, 0, 32'h0, 1'b0, 4'h0};
    m = model(v);
    run_xfer(v, res);
    compare("drain_a", m, res);
    v = '{1'b0, 32'h204, 32'h0, 4'h0, 0, 0, 32'h22222222, 1'b0, 3, 0, 0, 0, 32'h0, 1'b0, 4'h0};
    m = model(v);
    run_xfer(v, res);
    compare("drain_b", m, res);

    // No late response: drain gives up after TO cycles, then the next transfer is taken.
    idle(2);
    v = '{1'b0, 32'h300, 32'h0, 4'h0, 7, 5, 32'h33333333, 1'b0, -1, 0, 0, 0, 32'h0, 1'b0, 4'h0};
    m = model(v);
    run_xfer(v, res);
    compare("dexp_a", m, res);
    v = '{1'b1, 32'h304, 32'h44444444, 4'h6, 0, 0, 32'h55555555, 1'b0, -1, 8, 1, 10, 32'h0, 1'b0, 4'h6};
    run_xfer(v, res);
    compare("dexp_b", v, res);

    // Asynchronous reset in the middle of a request.
    idle(1);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h100; pwdata = 32'h99999999; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    chk("arst.req_before", {31'h0, req0}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst.ctl", {24'h0, req0, req1, we0, we1, pready0, pready1, pslverr0, pslverr1}, 32'h0);
    chk("arst.be", {24'h0, be0, be1}, 32'h0);
    chk("arst.addr", addr0 | addr1, 32'h0);
    chk("arst.wdata", wdata0 | wdata1, 32'h0);
    chk("arst.prdata", prdata0 | prdata1, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    v = '{1'b0, 32'h104, 32'h0, 4'h0, 0, 0, 32'h87654321, 1'b0, -1, 0, 0, 0, 32'h0, 1'b0, 4'h0};
    m = model(v);
    run_xfer(v, res);
    compare("post_rst", m, res);

    for (int i = 0; i < 40; i++) begin
      v.wr    = 1'($urandom_range(0, 1));
      v.addr  = $urandom & 32'hFFFF_FFFC;
      v.wdata = $urandom;
      v.strb  = 4'($urandom_range(0, 15));
      v.g     = $urandom_range(0, 3);
      v.r     = $urandom_range(0, 3);
      v.rdata = $urandom;
      v.err   = ($urandom_range(0, 3) == 0);
      v.lrv   = -1;
      m = model(v);
      run_xfer(m, res);
      compare($sformatf("rnd%0d", i), m, res);
      idle($urandom_range(0, 2));
    end

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
